// File: rtl/pipe_stage_hs.sv
// Two-entry valid/ready pipeline stage: main register plus skid register.
// All outputs, including in_ready, come straight from flops.
module pipe_stage_hs #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 18,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                main_vld_q, main_vld_d;
  logic                skid_vld_q, skid_vld_d;
  logic                in_ready_q, in_ready_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic                accept;
  logic                drain;

  assign accept = in_valid & in_ready_q;
  assign drain  = main_vld_q & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end
      end
      ONE: begin
        if (accept && !drain) begin
          state_d     = FULL;
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
        end else if (drain && !accept) begin
          state_d = EMPTY;
        end else if (accept && drain) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end
      end
      FULL: begin
        if (drain) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // A squashed accept must not leak into the held payload either.
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = main_data_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
    end
    if (state_d == EMPTY) begin
      main_ctrl_d = BUBBLE_CTRL;
    end
    main_vld_d = (state_d != EMPTY);
    skid_vld_d = (state_d == FULL);
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_vld_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_ctrl_q <= BUBBLE_CTRL;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_vld_q  <= main_vld_d;
      skid_vld_q  <= skid_vld_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_vld_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign occupancy = state_q;

  logic unused_skid_vld;
  assign unused_skid_vld = skid_vld_q;

endmodule
